// File: rtl/pulse_train_gen_if.sv
// Control and status bundle for pulse_train_gen: train requests and settings in,
// pulse output and train status out.
interface pulse_train_gen_if #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned NUM_W = 16
) ();
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] width;
    logic [NUM_W-1:0] num_pulses;
    logic             pulse_out;
    logic             busy;
    logic             done;
    logic [NUM_W-1:0] pulse_cnt;

    // Requester side: issues start/stop and settings, observes status.
    modport master (
        output start, stop, period, width, num_pulses,
        input  pulse_out, busy, done, pulse_cnt
    );

    // Generator side.
    modport slave (
        input  start, stop, period, width, num_pulses,
        output pulse_out, busy, done, pulse_cnt
    );
endinterface

// File: rtl/pulse_train_gen.sv
// Pulse train generator: emits num_pulses pulses (0 = run until stopped), each
// period cycles apart and width cycles high. Settings are sanitised and latched
// at start; every output is registered.
module pulse_train_gen #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned NUM_W = 16
) (
    input logic              clk,
    input logic              reset,
    pulse_train_gen_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;      // cycles remaining in current phase, minus one
    logic [CNT_W-1:0] per_q, per_d;      // sanitised period
    logic [CNT_W-1:0] wid_q, wid_d;      // sanitised high time
    logic [NUM_W-1:0] num_q, num_d;
    logic [NUM_W-1:0] pcnt_q, pcnt_d;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] pe_s, we_s;

    // Sanitise the live settings so they can be latched on start.
    always_comb begin
        pe_s = (bus.period < CNT_W'(2)) ? CNT_W'(2) : bus.period;
        if (bus.width == '0) begin
            we_s = CNT_W'(1);
        end else if (bus.width >= pe_s) begin
            we_s = pe_s - CNT_W'(1);
        end else begin
            we_s = bus.width;
        end
    end

    // Next state, phase counting and registered-output values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        wid_d   = wid_q;
        num_d   = num_q;
        pcnt_d  = pcnt_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                // stop wins over a simultaneous start
                if (bus.start && !bus.stop) begin
                    state_d = StHigh;
                    per_d   = pe_s;
                    wid_d   = we_s;
                    num_d   = bus.num_pulses;
                    cnt_d   = we_s - CNT_W'(1);
                    pcnt_d  = NUM_W'(1);
                end
            end
            StHigh: begin
                if (bus.stop) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    state_d = StLow;
                    cnt_d   = per_q - wid_q - CNT_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StLow: begin
                if (bus.stop) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    if ((num_q == '0) || (pcnt_q != num_q)) begin
                        state_d = StHigh;
                        cnt_d   = wid_q - CNT_W'(1);
                        pcnt_d  = pcnt_q + NUM_W'(1);  // wraps in continuous mode
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        pulse_d = (state_d == StHigh);
        busy_d  = (state_d != StIdle);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            per_q   <= '0;
            wid_q   <= '0;
            num_q   <= '0;
            pcnt_q  <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            wid_q   <= wid_d;
            num_q   <= num_d;
            pcnt_q  <= pcnt_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.pulse_out = pulse_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pulse_cnt = pcnt_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed self-checking bench for pulse_train_gen. Narrow counters keep the
// pulse_cnt wrap reachable in a short run.
module tb_pulse_train_gen;

    localparam int unsigned CW = 8;
    localparam int unsigned NW = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    pulse_train_gen_if #(.CNT_W(CW), .NUM_W(NW)) bus ();

    pulse_train_gen #(.CNT_W(CW), .NUM_W(NW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int p, input int w, input int n);
        bus.period     = CW'(p);
        bus.width      = CW'(w);
        bus.num_pulses = NW'(n);
    endtask

    // start must already be high in cycle N; bit i holds cycle N+1+i.
    task automatic capture(input int n, output logic [31:0] po, output logic [31:0] bz,
                           output logic [31:0] dn);
        po = '0;
        bz = '0;
        dn = '0;
        for (int i = 0; i < n; i++) begin
            step();
            if (i == 0) bus.start = 1'b0;
            po[i] = bus.pulse_out;
            bz[i] = bus.busy;
            dn[i] = bus.done;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b1;  // reset must win over start
        step();
        step();
        checks++;
        if ({bus.pulse_out, bus.busy, bus.done} !== 3'b000 || bus.pulse_cnt !== '0) begin
            errors++;
            $display("FAIL reset_outputs: po/busy/done=%b%b%b cnt=%0d, want 000 cnt=0",
                     bus.pulse_out, bus.busy, bus.done, bus.pulse_cnt);
        end
        bus.start = 1'b0;
        reset = 1'b0;
        step();
        step();
        checks++;
        if ({bus.pulse_out, bus.busy, bus.done} !== 3'b000) begin
            errors++;
            $display("FAIL post_reset_quiet: po/busy/done=%b%b%b, want 000",
                     bus.pulse_out, bus.busy, bus.done);
        end
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        step();
        checks++;
        if ({bus.pulse_out, bus.busy, bus.done} !== 3'b000 || bus.pulse_cnt !== '0) begin
            errors++;
            $display("FAIL stop_in_idle: po/busy/done=%b%b%b cnt=%0d, want 000 cnt=0",
                     bus.pulse_out, bus.busy, bus.done, bus.pulse_cnt);
        end
    endtask

    task automatic test_two_pulses();
        logic [31:0] po, bz, dn;
        set_cfg(10, 3, 2);
        bus.start = 1'b1;
        capture(24, po, bz, dn);
        checks++;
        if (po !== 32'h0000_1C07) begin
            errors++;
            $display("FAIL case1_pulse: got %h want %h", po, 32'h0000_1C07);
        end
        checks++;
        if (bz !== 32'h000F_FFFF) begin
            errors++;
            $display("FAIL case1_busy: got %h want %h", bz, 32'h000F_FFFF);
        end
        checks++;
        if (dn !== 32'h0010_0000) begin
            errors++;
            $display("FAIL case1_done: got %h want %h", dn, 32'h0010_0000);
        end
        checks++;
        if (bus.pulse_cnt !== NW'(2)) begin
            errors++;
            $display("FAIL case1_cnt: got %0d want 2", bus.pulse_cnt);
        end
    endtask

    task automatic test_min_period();
        logic [31:0] po, bz, dn;
        set_cfg(1, 0, 3);
        bus.start = 1'b1;
        capture(8, po, bz, dn);
        checks++;
        if (po !== 32'h15 || bz !== 32'h3F || dn !== 32'h40) begin
            errors++;
            $display("FAIL case2_min: po=%h busy=%h done=%h want 15 3f 40", po, bz, dn);
        end
    endtask

    task automatic test_wide_width();
        logic [31:0] po, bz, dn;
        set_cfg(5, 9, 1);
        bus.start = 1'b1;
        capture(8, po, bz, dn);
        checks++;
        if (po !== 32'h0F || bz !== 32'h1F || dn !== 32'h20) begin
            errors++;
            $display("FAIL case3_clamp: po=%h busy=%h done=%h want 0f 1f 20", po, bz, dn);
        end
        checks++;
        if (bus.pulse_cnt !== NW'(1)) begin
            errors++;
            $display("FAIL case3_cnt: got %0d want 1", bus.pulse_cnt);
        end
    endtask

    task automatic test_continuous_stop();
        logic saw_done;
        saw_done = 1'b0;
        set_cfg(4, 2, 0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            saw_done |= bus.done;
        end
        // now in cycle N+17, first high cycle of pulse 5
        checks++;
        if (bus.pulse_out !== 1'b1 || bus.pulse_cnt !== NW'(5)) begin
            errors++;
            $display("FAIL case4_fifth: po=%b cnt=%0d want 1 5", bus.pulse_out, bus.pulse_cnt);
        end
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        saw_done |= bus.done;
        checks++;
        if (bus.pulse_out !== 1'b0 || bus.busy !== 1'b0 || bus.pulse_cnt !== NW'(5)) begin
            errors++;
            $display("FAIL case4_stop: po=%b busy=%b cnt=%0d want 0 0 5",
                     bus.pulse_out, bus.busy, bus.pulse_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            saw_done |= bus.done | bus.busy;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL case4_no_done: got %b want 0", saw_done);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] po, bz, dn;
        // start with stop in idle: stop wins
        set_cfg(4, 2, 3);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        step();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        step();
        checks++;
        if (bus.busy !== 1'b0 || bus.pulse_out !== 1'b0) begin
            errors++;
            $display("FAIL case5_start_stop: busy=%b po=%b want 0 0", bus.busy, bus.pulse_out);
        end
        // train with start re-pulses and setting changes mid-train, then restart on done
        po = '0;
        bz = '0;
        dn = '0;
        bus.start = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step();
            po[i] = bus.pulse_out;
            bz[i] = bus.busy;
            dn[i] = bus.done;
            bus.start = (i == 3 || i == 5 || i == 12);
            if (i == 2) set_cfg(7, 1, 1);
        end
        bus.start = 1'b0;
        checks++;
        if (po !== 32'h2333) begin
            errors++;
            $display("FAIL case5_spacing: got %h want %h", po, 32'h2333);
        end
        checks++;
        if (bz !== 32'h2FFF || dn !== 32'h1000) begin
            errors++;
            $display("FAIL case5_busy_done: busy=%h done=%h want 2fff 1000", bz, dn);
        end
        checks++;
        if (bus.pulse_cnt !== NW'(1)) begin
            errors++;
            $display("FAIL case5_restart_cnt: got %0d want 1", bus.pulse_cnt);
        end
        // new train: period 7, width 1 -> low from next cycle
        step();
        checks++;
        if (bus.pulse_out !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL case5_new_width: po=%b busy=%b want 0 1", bus.pulse_out, bus.busy);
        end
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
    endtask

    task automatic test_reset_mid_train();
        logic any_act;
        any_act = 1'b0;
        set_cfg(4, 1, 3);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();  // cycle N+2, in LOW
        reset = 1'b1;
        step();
        checks++;
        if ({bus.pulse_out, bus.busy, bus.done} !== 3'b000 || bus.pulse_cnt !== '0) begin
            errors++;
            $display("FAIL case6_reset: po/busy/done=%b%b%b cnt=%0d want 000 0",
                     bus.pulse_out, bus.busy, bus.done, bus.pulse_cnt);
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            any_act |= bus.pulse_out | bus.busy | bus.done;
        end
        checks++;
        if (any_act !== 1'b0) begin
            errors++;
            $display("FAIL case6_quiet: activity=%b want 0", any_act);
        end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++;
        if (bus.pulse_out !== 1'b1 || bus.busy !== 1'b1 || bus.pulse_cnt !== NW'(1)) begin
            errors++;
            $display("FAIL case6_fresh: po=%b busy=%b cnt=%0d want 1 1 1",
                     bus.pulse_out, bus.busy, bus.pulse_cnt);
        end
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
    endtask

    task automatic test_wrap();
        set_cfg(2, 0, 0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 30; i++) step();
        // cycle N+31: pulse 16 -> count wraps to 0
        checks++;
        if (bus.pulse_out !== 1'b1 || bus.pulse_cnt !== NW'(0)) begin
            errors++;
            $display("FAIL wrap_16: po=%b cnt=%0d want 1 0", bus.pulse_out, bus.pulse_cnt);
        end
        step();
        step();
        checks++;
        if (bus.pulse_out !== 1'b1 || bus.pulse_cnt !== NW'(1)) begin
            errors++;
            $display("FAIL wrap_17: po=%b cnt=%0d want 1 1", bus.pulse_out, bus.pulse_cnt);
        end
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        set_cfg(0, 0, 0);
        test_reset();
        test_two_pulses();
        test_min_period();
        test_wide_width();
        test_continuous_stop();
        test_back_to_back();
        test_reset_mid_train();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
